scandoubler_mode_ctrl: RTL
==========================

// Module: scandoubler_mode_ctrl
// PURPOSE
// Configures the scandoubler from the incoming video timing.
// - Measures the hsync period and the lines per frame in clk_sys cycles.
// - Classifies the input as 15 kHz (needs doubling) or 31 kHz (already VGA rate).
// - Drives the scandoubler's bypass, ce_divider and scanlines inputs. Changes are glitch-free: they are committed only at frame start, after the timing has been stable for several frames.
// - Sits between the core's video outputs and the scandoubler; shares clk_sys with it.
// PARAMETERS
// HCNT_W        13    width of hsync-period counter; saturation value = timeout
// LCNT_W        11    width of line counter / lines_per_frame
// HS_THRESH     2300  period (clk_sys cycles) below which a line is high-rate
// STABLE_FRAMES 3     consecutive identical frames required to commit a mode (1..15)
// DIV_LO        3'd3  ce_divider value for the 15 kHz (doubled) mode
// DIV_HI        3'd1  ce_divider value for the 31 kHz (bypass) mode
// PORTS
// clk_sys         in   1       system clock, same as the scandoubler
// reset_n         in   1       asynchronous active-low reset
// hs_in           in   1       input hsync; falling edge = line start
// vs_in           in   1       input vsync; rising edge = frame start
// scanlines_req   in   2       requested scanline strength (00 none .. 11 75%)
// bypass          out  1       to scandoubler bypass
// ce_divider      out  3       to scandoubler ce_divider
// scanlines       out  2       to scandoubler scanlines
// mode_valid      out  1       a mode is locked
// line_rate_hi    out  1       locked mode is 31 kHz
// lines_per_frame out  LCNT_W  lines counted in the last complete frame (saturating)
// mode_change     out  1       one-cycle pulse when the committed mode changes
// BEHAVIOUR
// - Reset values:
//   - bypass=1, ce_divider=DIV_LO, scanlines=0, mode_valid=0, line_rate_hi=0.
//   - lines_per_frame=0, mode_change=0.
//   - state=NOSIG; all counters 0.
// - Edges: hs_in and vs_in are registered once (hsD, vsD); edges are detected against the registered copy.
// - Period counter:
//   - Increments every cycle and saturates at 2^HCNT_W-1.
//   - On an hs falling edge: classify the line (hi if period < HS_THRESH), clear to 0, increment the line counter (saturating).
// - Per-frame class tracks whether all lines were hi, all lo, or mixed. Mixed marks the frame unstable.
// - States:
//   - NOSIG -> ACQUIRE on the first hs falling edge.
//   - ACQUIRE: the first vs rising edge only opens a frame; it is not evaluated.
//   - On each later vs rising edge:
//     - latch lines_per_frame;
//     - if the class equals the candidate, increment the stable count (saturating at 15);
//     - otherwise load the new class as candidate and set the stable count to 1 (0 if mixed).
//   - Commit when the stable count reaches STABLE_FRAMES: enter LOCKED, mode_valid=1, line_rate_hi=candidate.
//   - LOCKED: the same evaluation continues. A different stable candidate re-commits and pulses mode_change; mode_valid stays 1.
//   - Any state -> NOSIG when the period counter saturates (timeout): bypass=1, mode_valid=0, stable count 0.
// - Outputs are registered and updated only in the cycle after a vs rising edge (or at timeout):
//   - bypass = NOSIG | line_rate_hi
//   - ce_divider = line_rate_hi ? DIV_HI : DIV_LO
//   - scanlines = bypass ? 2'b00 : scanlines_req, sampled at that same frame edge
// - mode_change:
//   - Pulses for exactly one cycle, coincident with an output update that changes bypass or ce_divider.
//   - No pulse when scanlines alone changes.
// - Simultaneous hs and vs edges: the line is counted and classified into the ending frame first, then the frame is evaluated.
// - An asynchronous reset mid-frame returns everything to the reset values immediately.
// CONFIGURATION
// SD_MODE_FORCE_EN defined:
// - Adds input force_mode[1:0]: 00/11 = auto, 01 = force lo, 10 = force hi.
// - A forced mode overrides line_rate_hi for bypass/ce_divider at the next frame edge, even in NOSIG.
// - mode_valid and lines_per_frame still report the detected timing.
// - mode_change pulses on any effective change.
// SD_MODE_FORCE_EN undefined: the port is absent; auto only.
// TESTING
// - Reset with no sync -> bypass=1, ce_divider=3, scanlines=0, mode_valid=0.
// - hs period 3000, 312 lines/frame, scanlines_req=2:
//   - after the 4th vs edge: bypass=0, ce_divider=3, scanlines=2, mode_valid=1, lines_per_frame=312;
//   - exactly one mode_change pulse.
// - Locked lo, then switch to period 1500, 525 lines:
//   - stays lo for 2 hi frames (3 edges incl. transition);
//   - then bypass=1, ce_divider=1, scanlines=0, one pulse.
// - Locked lo, one frame with mixed 3000/1500 periods -> no change; the stable count restarts and no pulse occurs.
// - Locked, hs held high for 8191 cycles -> NOSIG: bypass=1, mode_valid=0.
// - scanlines_req changed mid-frame -> scanlines changes only in the cycle after the next vs edge, with no mode_change pulse.
// - (SD_MODE_FORCE_EN) locked lo, force_mode=10 -> bypass=1, ce_divider=1 at the next vs edge; mode_valid=1, line_rate_hi=0.

Source files
------------

// File: rtl/scandoubler_mode_ctrl.sv
// -----------------------------------------------------------------------------
// scandoubler_mode_ctrl
//
// Watches the core's raw sync outputs and decides how the scandoubler should
// be configured. The hsync period is measured in clk_sys cycles to classify
// every line as low rate (15 kHz, needs doubling) or high rate (31 kHz,
// already VGA rate). A frame whose lines all share one class becomes a
// candidate mode. The candidate is committed only after it has been seen for
// STABLE_FRAMES consecutive frames. The scandoubler controls are registered
// and change only in the cycle after a vsync rising edge, or when sync is
// lost, so the scandoubler never sees a mid-frame reconfiguration.
//
// Ports
//   clk_sys          in   system clock shared with the scandoubler
//   reset_n          in   asynchronous active-low reset
//   hs_in            in   hsync, falling edge marks a line start
//   vs_in            in   vsync, rising edge marks a frame start
//   scanlines_req    in   requested scanline strength (00 none .. 11 75%)
//   force_mode       in   (SD_MODE_FORCE_EN only) 00/11 auto, 01 lo, 10 hi
//   bypass           out  scandoubler bypass
//   ce_divider       out  scandoubler pixel clock-enable divider
//   scanlines        out  scandoubler scanline strength
//   mode_valid       out  a mode has been locked
//   line_rate_hi     out  locked mode is 31 kHz
//   lines_per_frame  out  lines counted in the last complete frame
//   mode_change      out  one-cycle pulse when bypass/ce_divider change
//
// Build option
//   SD_MODE_FORCE_EN  adds force_mode, which overrides the detected rate for
//                     bypass/ce_divider at the next frame edge. Detection and
//                     mode_valid/line_rate_hi/lines_per_frame are unaffected.
//
// States
//   NOSIG   | no hsync activity (or period timeout); scandoubler bypassed
//   ACQUIRE | hsync present, waiting for the first vsync to open a frame
//   TRACK   | frames being evaluated, no mode committed yet
//   LOCKED  | a mode is committed; evaluation continues to catch changes
// -----------------------------------------------------------------------------
module scandoubler_mode_ctrl #(
  parameter int         HCNT_W        = 13,
  parameter int         LCNT_W        = 11,
  parameter int         HS_THRESH     = 2300,
  parameter int         STABLE_FRAMES = 3,
  parameter logic [2:0] DIV_LO        = 3'd3,
  parameter logic [2:0] DIV_HI        = 3'd1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [1:0]        scanlines_req,
`ifdef SD_MODE_FORCE_EN
  input  logic [1:0]        force_mode,
`endif
  output logic              bypass,
  output logic [2:0]        ce_divider,
  output logic [1:0]        scanlines,
  output logic              mode_valid,
  output logic              line_rate_hi,
  output logic [LCNT_W-1:0] lines_per_frame,
  output logic              mode_change
);

  typedef enum logic [1:0] {
    S_NOSIG   = 2'd0,
    S_ACQUIRE = 2'd1,
    S_TRACK   = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  localparam logic [HCNT_W-1:0] HCNT_MAX   = '1;
  localparam logic [LCNT_W-1:0] LCNT_MAX   = '1;
  localparam logic [HCNT_W-1:0] HS_LIMIT   = HCNT_W'(HS_THRESH);
  localparam logic [3:0]        STABLE_REQ = 4'(STABLE_FRAMES);

  // Frame class is {saw_hi_line, saw_lo_line}: 01 lo, 10 hi, 11 mixed,
  // 00 empty. Only 01 and 10 can build up a stable candidate.
  localparam logic [1:0] CLS_NONE = 2'b00;
  localparam logic [1:0] CLS_MIX  = 2'b11;

  state_t              state_q, state_d;
  logic                hs_q, vs_q;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic                seen_hi_q, seen_hi_d;
  logic                seen_lo_q, seen_lo_d;
  logic [1:0]          cand_q, cand_d;
  logic [3:0]          stable_q, stable_d;
  logic [LCNT_W-1:0]   lpf_q, lpf_d;
  logic                mode_valid_q, mode_valid_d;
  logic                line_rate_hi_q, line_rate_hi_d;
  logic                bypass_q, bypass_d;
  logic [2:0]          ce_q, ce_d;
  logic [1:0]          scan_q, scan_d;
  logic                mode_change_q, mode_change_d;

  logic                hs_fall, vs_rise, timeout, line_hi, upd;
  logic [LCNT_W-1:0]   lcnt_line;
  logic                seen_hi_line, seen_lo_line;
  logic [1:0]          frame_cls;
  logic                eff_hi, bypass_new;
  logic [2:0]          ce_new;

  assign hs_fall = hs_q & ~hs_in;
  assign vs_rise = vs_in & ~vs_q;
  // Timeout is an event only outside NOSIG; in NOSIG the counter just sits
  // saturated until hsync returns.
  assign timeout = (hcnt_q == HCNT_MAX) && (state_q != S_NOSIG);
  assign line_hi = (hcnt_q < HS_LIMIT);

  always_comb begin
    state_d        = state_q;
    hcnt_d         = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + 1'b1;
    lcnt_d         = lcnt_q;
    seen_hi_d      = seen_hi_q;
    seen_lo_d      = seen_lo_q;
    cand_d         = cand_q;
    stable_d       = stable_q;
    lpf_d          = lpf_q;
    mode_valid_d   = mode_valid_q;
    line_rate_hi_d = line_rate_hi_q;
    bypass_d       = bypass_q;
    ce_d           = ce_q;
    scan_d         = scan_q;
    mode_change_d  = 1'b0;
    upd            = 1'b0;
    eff_hi         = 1'b0;
    bypass_new     = 1'b1;
    ce_new         = DIV_LO;

    // The line that ends on this cycle belongs to the frame that is ending,
    // so it is folded in before any frame evaluation below.
    lcnt_line    = lcnt_q;
    seen_hi_line = seen_hi_q;
    seen_lo_line = seen_lo_q;
    if (hs_fall) begin
      hcnt_d = '0;
      if (lcnt_q != LCNT_MAX) lcnt_line = lcnt_q + 1'b1;
      if (line_hi) seen_hi_line = 1'b1;
      else         seen_lo_line = 1'b1;
    end
    lcnt_d    = lcnt_line;
    seen_hi_d = seen_hi_line;
    seen_lo_d = seen_lo_line;
    frame_cls = {seen_hi_line, seen_lo_line};

    if (timeout) begin
      state_d        = S_NOSIG;
      mode_valid_d   = 1'b0;
      line_rate_hi_d = 1'b0;
      stable_d       = '0;
      cand_d         = CLS_NONE;
      lcnt_d         = '0;
      seen_hi_d      = 1'b0;
      seen_lo_d      = 1'b0;
      upd            = 1'b1;
    end else begin
      unique case (state_q)
        S_NOSIG: begin
          // hsync returning on a frame edge opens that frame straight away.
          if (hs_fall) state_d = vs_rise ? S_TRACK : S_ACQUIRE;
        end
        S_ACQUIRE: begin
          if (vs_rise) state_d = S_TRACK;
        end
        S_TRACK, S_LOCKED: begin
          if (vs_rise) begin
            lpf_d = lcnt_line;
            if ((frame_cls == CLS_MIX) || (frame_cls == CLS_NONE)) begin
              cand_d   = frame_cls;
              stable_d = '0;
            end else if (frame_cls == cand_q) begin
              stable_d = (stable_q == 4'hF) ? stable_q : stable_q + 1'b1;
            end else begin
              cand_d   = frame_cls;
              stable_d = 4'd1;
            end
            // Equality, not >=, so a long-stable mode commits exactly once.
            if (stable_d == STABLE_REQ) begin
              state_d        = S_LOCKED;
              mode_valid_d   = 1'b1;
              line_rate_hi_d = frame_cls[1];
            end
          end
        end
        default: state_d = S_NOSIG;
      endcase

      if (vs_rise) begin
        lcnt_d    = '0;
        seen_hi_d = 1'b0;
        seen_lo_d = 1'b0;
        upd       = 1'b1;
      end
    end

    // Until a mode is locked the scandoubler stays bypassed at the low-rate
    // divider, matching the reset configuration.
    eff_hi     = line_rate_hi_d;
    bypass_new = ~mode_valid_d | line_rate_hi_d;
`ifdef SD_MODE_FORCE_EN
    if (force_mode == 2'b01 || force_mode == 2'b10) begin
      eff_hi     = force_mode[1];
      bypass_new = force_mode[1];
    end
`endif
    ce_new = eff_hi ? DIV_HI : DIV_LO;

    if (upd) begin
      bypass_d      = bypass_new;
      ce_d          = ce_new;
      scan_d        = bypass_new ? 2'b00 : scanlines_req;
      mode_change_d = (bypass_new != bypass_q) || (ce_new != ce_q);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_NOSIG;
      hs_q           <= 1'b0;
      vs_q           <= 1'b0;
      hcnt_q         <= '0;
      lcnt_q         <= '0;
      seen_hi_q      <= 1'b0;
      seen_lo_q      <= 1'b0;
      cand_q         <= CLS_NONE;
      stable_q       <= '0;
      lpf_q          <= '0;
      mode_valid_q   <= 1'b0;
      line_rate_hi_q <= 1'b0;
      bypass_q       <= 1'b1;
      ce_q           <= DIV_LO;
      scan_q         <= 2'b00;
      mode_change_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      hs_q           <= hs_in;
      vs_q           <= vs_in;
      hcnt_q         <= hcnt_d;
      lcnt_q         <= lcnt_d;
      seen_hi_q      <= seen_hi_d;
      seen_lo_q      <= seen_lo_d;
      cand_q         <= cand_d;
      stable_q       <= stable_d;
      lpf_q          <= lpf_d;
      mode_valid_q   <= mode_valid_d;
      line_rate_hi_q <= line_rate_hi_d;
      bypass_q       <= bypass_d;
      ce_q           <= ce_d;
      scan_q         <= scan_d;
      mode_change_q  <= mode_change_d;
    end
  end

  assign bypass          = bypass_q;
  assign ce_divider      = ce_q;
  assign scanlines       = scan_q;
  assign mode_valid      = mode_valid_q;
  assign line_rate_hi    = line_rate_hi_q;
  assign lines_per_frame = lpf_q;
  assign mode_change     = mode_change_q;

endmodule
